// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - 8N1 UART receiver with oversampled bit timing and a one-deep output register
module serial_rx #(
    parameter int INPUT_FREQUENCY = 25000000,
    parameter int BAUD_RATE       = 115200,
    parameter int OVERSAMPLE      = 8,
    parameter int BAUD_GEN_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);
    localparam int TICK_DIV_RAW = INPUT_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
    localparam int OS_W         = $clog2(OVERSAMPLE);

    localparam logic [BAUD_GEN_WIDTH-1:0] TICK_LAST = BAUD_GEN_WIDTH'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]           OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]           OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t                    state_q, state_d;
    logic                      rx_meta_q, rx_meta_d;
    logic                      rx_s_q, rx_s_d;
    logic [BAUD_GEN_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]           os_cnt_q, os_cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [7:0]                shift_q, shift_d;
    logic [7:0]                data_q, data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      frame_error_q, frame_error_d;
    logic                      overrun_q, overrun_d;
    logic                      tick, sample, deliver, stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            tick_cnt_q    <= '0;
            os_cnt_q      <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_meta_q     <= rx_meta_d;
            rx_s_q        <= rx_s_d;
            tick_cnt_q    <= tick_cnt_d;
            os_cnt_q      <= os_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            rx_valid_q    <= rx_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    // Synchroniser and free-running sample tick, independent of frame activity.
    always_comb begin
        rx_meta_d  = rx;
        rx_s_d     = rx_meta_q;
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + BAUD_GEN_WIDTH'(1);
    end

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d  = S_START;
                        os_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (os_cnt_q == OS_HALF) begin
                        os_cnt_d  = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s_q ? S_IDLE : S_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                S_DATA: begin
                    if (os_cnt_q == OS_LAST) begin
                        shift_d[bit_idx_q] = rx_s_q;
                        os_cnt_d           = '0;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                S_STOP: begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        state_d  = rx_s_q ? S_IDLE : S_BREAK;
                    end else begin
                        os_cnt_d = os_cnt_q + OS_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sample   = tick && (os_cnt_q == OS_LAST) && (state_q == S_STOP);
        deliver  = sample && rx_s_q;
        stop_bad = sample && !rx_s_q;
        busy     = (state_q != S_IDLE);
    end

    // A same-cycle accept frees the register, so a new byte may replace the old one without overrun.
    always_comb begin
        data_d        = data_q;
        rx_valid_d    = rx_valid_q;
        overrun_d     = 1'b0;
        frame_error_d = stop_bad;
        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                data_d     = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign data        = data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - directed bench for serial_rx at 16 clk per bit with a byte scoreboard
module tb_serial_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] data;
    logic       rx_valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    serial_rx #(
        .INPUT_FREQUENCY(1600000),
        .BAUD_RATE      (100000),
        .OVERSAMPLE     (8),
        .BAUD_GEN_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_ready   (rx_ready),
        .data       (data),
        .rx_valid   (rx_valid),
        .frame_error(frame_error),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int         cyc;
    int         checks = 0;
    int         failures = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic       fe_prev = 1'b0;
    logic       ov_prev = 1'b0;
    logic [7:0] exp_q[$];
    int         lat;
    int         n;
    int         fe_base;
    int         ov_base;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_error === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (frame_error === 1'b1 || overrun === 1'b1)
            check("pulse_single", 32'({frame_error & overrun, frame_error & fe_prev, overrun & ov_prev}), 32'd0);
        fe_prev = frame_error;
        ov_prev = overrun;
    end

    // Frames start on an even cycle so the sample-tick phase is the same for every frame.
    task automatic align();
        if (cyc % 2 != 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        align();
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (rx_valid !== 1'b1 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 32'(rx_valid), 32'd1);
    endtask

    task automatic consume(input string tag);
        logic [7:0] e;
        wait_valid({tag, "_valid"}, 400);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_data"}, 32'(data), 32'(e));
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        check({tag, "_clr"}, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({data, rx_valid, frame_error, overrun, busy}), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // 1: single frame, latency from the start edge
        exp_q.push_back(8'h55);
        align();
        fork
            send_frame(8'h55, 1'b1);
            begin
                lat = 0;
                while (rx_valid !== 1'b1 && lat < 200) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check("t1_latency", 32'(lat >= 152 && lat <= 160), 32'd1);
                check("t1_busy_low", 32'(busy), 32'd0);
            end
        join
        check("t1_flags", 32'(fe_cnt + ov_cnt), 32'd0);
        consume("t1");

        // 2: back-to-back frames, ack lands on the cycle the second byte arrives
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h3C);
        send_frame(8'hA3, 1'b1);
        align();
        fork
            send_frame(8'h3C, 1'b1);
            begin
                repeat (lat - 1) @(posedge clk);
                #1;
                check("t2_old_valid", 32'(rx_valid), 32'd1);
                check("t2_old_data", 32'(data), 32'(exp_q[0]));
                rx_ready = 1'b1;
                @(posedge clk); #1;
                rx_ready = 1'b0;
                void'(exp_q.pop_front());
                check("t2_valid_held", 32'(rx_valid), 32'd1);
                check("t2_new_data", 32'(data), 32'(exp_q[0]));
            end
        join
        check("t2_no_overrun", 32'(ov_cnt), 32'd0);
        consume("t2");

        // 3: second byte arrives while the first is still held
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("t3_overrun_count", 32'(ov_cnt), 32'd1);
        check("t3_frame_error", 32'(fe_cnt), 32'd0);
        consume("t3");

        // 4: short glitch is rejected at the mid-start re-sample
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        align();
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_busy_fall", 32'(busy), 32'd0);
        repeat (32) @(posedge clk);
        #1;
        check("t4_no_valid", 32'(rx_valid), 32'd0);
        check("t4_no_flags", 32'((fe_cnt - fe_base) + (ov_cnt - ov_base)), 32'd0);

        // 5: low stop bit followed by a held-low line, then a good frame
        send_frame(8'h81, 1'b0);
        repeat (48) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (32) @(posedge clk);
        #1;
        check("t5_one_frame_error", 32'(fe_cnt - fe_base), 32'd1);
        check("t5_no_overrun", 32'(ov_cnt - ov_base), 32'd0);
        check("t5_no_valid", 32'(rx_valid), 32'd0);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        consume("t5");

        // 6: reset in the middle of bit 4 with a byte held
        send_frame(8'h11, 1'b1);
        check("t6_held_valid", 32'(rx_valid), 32'd1);
        align();
        rx = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (16) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_clear", 32'({data, rx_valid, frame_error, overrun, busy}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_hold_clear", 32'({rx_valid, busy}), 32'd0);
        rx = 1'b1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        consume("t6");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
UART receiver that recovers 8N1 bytes from the asynchronous line driven by the SerialTX block, using an oversampled bit clock.
- Frame: one start bit, 8 data bits LSB first, stop bit(s).
- Received byte is held in a one-deep output register with a valid/ready handshake for the consumer (CPU I/O port or loopback logic).
- Framing errors and overruns are flagged.

Parameters:
inputFrequency, 25000000, clk frequency in Hz
baudRate, 115200, line bit rate
oversample, 8, sample ticks per bit; even, >= 4
baudGenWidth, 16, width of the tick divider counter
tickDiv, inputFrequency/(baudRate*oversample), clk cycles per sample tick (integer division, >= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  serial line, idle high, asynchronous to clk
rx_ready  in  1  consumer accepts the held byte
data  out  8  received byte; stable while rx_valid=1
rx_valid  out  1  held byte available
frame_error  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: byte lost because the holding register was full
busy  out  1  receiver state != IDLE

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; sync FFs=1; tick counter=0; os_cnt=0; bit index=0.
- data=0, rx_valid=0, frame_error=0, overrun=0, busy=0.
- Applies mid-frame: a partial frame is discarded and rx_valid is cleared.

Input synchronisation:
- rx passes through 2 flip-flops to give rx_s; all decisions use rx_s only.

Tick generator:
- Free-running counter 0..tickDiv-1; tick=1 for one clk when count==tickDiv-1, then wraps to 0.
- Never reset by frame activity.

State machine (advances only on tick cycles):
- IDLE: if rx_s=0 -> START, os_cnt=0.
- START: os_cnt++. When os_cnt reaches oversample/2-1 (mid start bit), re-sample:
  - rx_s=0 -> DATA, os_cnt=0, bit index=0.
  - rx_s=1 -> false start (glitch) -> IDLE, no flags.
- DATA: os_cnt++. When os_cnt==oversample-1, sample rx_s into shift register bit[index], os_cnt=0, index++.
  - After bit 7 -> STOP.
- STOP: same timing. On sample:
  - rx_s=1 -> deliver byte -> IDLE.
  - rx_s=0 -> frame_error pulse, byte discarded -> BREAK.
- BREAK: stay until rx_s=1 is sampled on a tick -> IDLE. No further frame_error pulses while the line is held low.

Output register and handshake:
- Accept: a clk with rx_valid=1 and rx_ready=1 clears rx_valid on the next edge.
- Deliver with rx_valid=0: data<=byte, rx_valid<=1 on the next edge.
- Deliver with rx_valid=1 and rx_ready=1 in the same clk: data<=new byte, rx_valid stays 1, no overrun.
- Deliver with rx_valid=1 and rx_ready=0: data keeps the old byte, new byte dropped, overrun pulses 1 clk.
- rx_ready while rx_valid=0: ignored.
- frame_error and overrun are never asserted together; each lasts exactly 1 clk.

Latency:
- rx_valid rises 1 clk after the tick that samples the stop bit, about 9.5 bit times after the start edge.
- Start detection skew: up to 2 clk (synchroniser) + 1 tick.
- Multiple stop bits from the transmitter are absorbed in IDLE.

Test Plan (sim params: inputFrequency=1600000, baudRate=100000, oversample=8 -> tickDiv=2, 16 clk/bit):
1. Drive frame 0x55 at 16 clk/bit, rx_ready=0 -> rx_valid=1 within 152..160 clk of start edge; data=0x55; frame_error=0, overrun=0; busy low after stop.
2. Send 0xA3, then 0x3C back-to-back with one stop bit each; ack 0xA3 as 0x3C completes -> data=0x3C, rx_valid stays 1, no overrun.
3. Send 0x01 then 0xFF, never asserting rx_ready -> data stays 0x01; one overrun pulse at the 0xFF stop sample.
4. Pulse rx low for 4 clk only -> returns to IDLE, busy falls within 12 clk; no rx_valid, no flags.
5. Send 0x81 with stop bit low, then hold rx low for 3 bit times -> exactly one frame_error pulse, rx_valid=0; a following good 0x42 is received correctly.
6. Assert rst_n=0 mid-bit 4 with rx_valid=1 -> all outputs 0 immediately; after release, a frame 0x7E is received cleanly.
